gate16_checker: RTL and testbench
=================================

Name: gate16_checker

Overview:
- Sequential response checker for the 16-bit bitwise gate family (AND16/OR16/XOR16/NAND16). It is the receiving end of gate stimulus.
- A stimulus source or bench drives (x, y, dut_out) vectors through a valid/ready handshake. The block recomputes the golden result, counts vectors and mismatches, and captures the first failure.
- It replaces eyeball $monitor inspection with a synthesizable pass/fail verdict usable on FPGA or in simulation.

Parameters:
- WIDTH, 16, data width of x, y, dut_out.
- CNT_W, 16, width of vector and error counters.
- OP, 0, golden function: 0=AND, 1=OR, 2=XOR, 3=NAND. Any other value behaves as AND.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  pulse; begins a check run and clears all results.
- stop  input  1  pulse; ends the run.
- in_valid  input  1  vector present on x/y/dut_out.
- in_ready  output  1  checker accepts a vector this cycle.
- x  input  WIDTH  stimulus operand A.
- y  input  WIDTH  stimulus operand B.
- dut_out  input  WIDTH  DUT response for (x, y).
- busy  output  1  high in RUN or DRAIN.
- done  output  1  run finished; results stable.
- pass  output  1  done and err_count==0.
- vec_count  output  CNT_W  vectors accepted.
- err_count  output  CNT_W  mismatching vectors.
- first_err_idx  output  CNT_W  vec_count index (0-based) of first mismatch.
- first_err_exp  output  WIDTH  golden value at first mismatch.
- first_err_got  output  WIDTH  dut_out at first mismatch.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs are 0: in_ready, busy, done, pass, every counter and every capture register.
- States and transitions:
  - IDLE: start -> RUN.
  - RUN: stop -> DRAIN.
  - DRAIN: always -> DONE after 1 cycle.
  - DONE: start -> RUN.
- Entering RUN clears vec_count, err_count, the first_err_* registers, done and pass in the same edge.
- in_ready=1 only in RUN, and it is a registered output. A vector is accepted on a clk edge with in_valid && in_ready.
- Pipeline:
  - Accept edge: x, y and dut_out are registered into stage 1, and vec_count increments.
  - Next edge: stage 1 is compared with golden = OP(x, y). On mismatch, err_count increments.
  - Compare latency is 1 cycle after acceptance.
- First-failure capture: on the first mismatch of a run, latch first_err_idx (the index of that vector), first_err_exp and first_err_got. Later mismatches do not overwrite them.
- Counters saturate at all-ones. Once vec_count saturates, further vectors are still compared, but first_err_idx for later failures is not meaningful.
- stop together with an accepted vector in RUN: the vector is accepted. DRAIN retires it, so it is counted and compared before done.
- start and stop together in IDLE or DONE: start wins and stop is ignored.
- start in RUN or DRAIN is ignored. stop in IDLE, DRAIN or DONE is ignored.
- done=1 and pass=(err_count==0) are set on the DRAIN->DONE edge. Both hold until the next start or reset.
- A zero-vector run (start then stop) ends with done=1, pass=1 and both counts 0.
- Reset mid-run aborts immediately to IDLE with all outputs cleared. No partial results are retained.

Optional Feature:
- Macro: GATE16_CHK_HALT_ON_ERR_EN.
- When defined: the first mismatch forces RUN -> DRAIN automatically. in_ready deasserts on the edge after the compare. Vectors already accepted are still compared and counted.
- When not defined: the run continues until stop, and all vectors are checked.

Test Plan:
- OP=0, reset, start, vectors (0000,0000,0000), (0001,0001,0001), (1263,2462,0062), (0001,0000,0000), stop -> done=1, pass=1, vec_count=4, err_count=0.
- OP=0, vectors as above but third dut_out=0063, plus fourth dut_out=0001 -> err_count=2, pass=0, first_err_idx=2, first_err_exp=0062, first_err_got=0063.
- OP=2 (XOR), vector (FFFF,0F0F,F0F0) in the same cycle as a stop pulse -> vector counted, vec_count=1, pass=1; done asserts 2 edges after stop.
- rst_n=0 asynchronously mid-RUN after 3 vectors -> all outputs 0 immediately, state IDLE, in_ready=0. A later start gives a fresh run with vec_count from 0.
- start, then stop with no vectors -> done=1, pass=1, counts 0. A second start clears done and pass on the next edge.
- With GATE16_CHK_HALT_ON_ERR_EN, OP=0, mismatch at vector 1 of 5 offered -> in_ready drops, vec_count ≤ 3, err_count ≥ 1, first_err_idx=1, done=1, pass=0.

Source files
------------

// File: rtl/gate16_checker.sv
// rtl/gate16_checker.sv - response checker for the 16-bit AND/OR/XOR/NAND gate family
// Optional halt-on-first-error behaviour: define GATE16_CHK_HALT_ON_ERR_EN.
module gate16_checker #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16,
  parameter int OP    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_got
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_done;
  logic             r_pass;
  logic [CNT_W-1:0] r_vec_count;
  logic [CNT_W-1:0] r_err_count;
  logic [CNT_W-1:0] r_first_err_idx;
  logic [WIDTH-1:0] r_first_err_exp;
  logic [WIDTH-1:0] r_first_err_got;
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_x;
  logic [WIDTH-1:0] r_s1_y;
  logic [WIDTH-1:0] r_s1_got;
  logic [CNT_W-1:0] r_s1_idx;

  logic [WIDTH-1:0] w_golden;
  logic             w_accept;
  logic             w_mismatch;
  logic             w_halt;
  logic [CNT_W-1:0] w_err_next;

  always_comb begin
    case (OP)
      1:       w_golden = r_s1_x | r_s1_y;
      2:       w_golden = r_s1_x ^ r_s1_y;
      3:       w_golden = ~(r_s1_x & r_s1_y);
      default: w_golden = r_s1_x & r_s1_y;
    endcase
  end

  assign w_accept   = in_valid && r_in_ready;
  assign w_mismatch = r_s1_valid && (w_golden != r_s1_got);
  assign w_err_next = (w_mismatch && (r_err_count != '1)) ? r_err_count + 1'b1 : r_err_count;

`ifdef GATE16_CHK_HALT_ON_ERR_EN
  assign w_halt = w_mismatch;
`else
  assign w_halt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_in_ready      <= 1'b0;
      r_done          <= 1'b0;
      r_pass          <= 1'b0;
      r_vec_count     <= '0;
      r_err_count     <= '0;
      r_first_err_idx <= '0;
      r_first_err_exp <= '0;
      r_first_err_got <= '0;
      r_s1_valid      <= 1'b0;
      r_s1_x          <= '0;
      r_s1_y          <= '0;
      r_s1_got        <= '0;
      r_s1_idx        <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_x   <= x;
        r_s1_y   <= y;
        r_s1_got <= dut_out;
        r_s1_idx <= r_vec_count;
        if (r_vec_count != '1) r_vec_count <= r_vec_count + 1'b1;
      end
      r_err_count <= w_err_next;
      // err_count saturates and never returns to zero, so zero marks the first failure
      if (w_mismatch && (r_err_count == '0)) begin
        r_first_err_idx <= r_s1_idx;
        r_first_err_exp <= w_golden;
        r_first_err_got <= r_s1_got;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state         <= S_RUN;
            r_in_ready      <= 1'b1;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_vec_count     <= '0;
            r_err_count     <= '0;
            r_first_err_idx <= '0;
            r_first_err_exp <= '0;
            r_first_err_got <= '0;
            r_s1_valid      <= 1'b0;
          end
        end
        S_RUN: begin
          if (stop || w_halt) begin
            r_state    <= S_DRAIN;
            r_in_ready <= 1'b0;
          end
        end
        S_DRAIN: begin
          // The last accepted vector is compared on this same edge
          r_state <= S_DONE;
          r_done  <= 1'b1;
          r_pass  <= (w_err_next == '0);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign busy          = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done          = r_done;
  assign pass          = r_pass;
  assign vec_count     = r_vec_count;
  assign err_count     = r_err_count;
  assign first_err_idx = r_first_err_idx;
  assign first_err_exp = r_first_err_exp;
  assign first_err_got = r_first_err_got;

endmodule

// File: tb/tb_gate16_checker.sv
// tb/tb_gate16_checker.sv - bench for gate16_checker (AND/16-bit counters and XOR/4-bit counters)
// Vectors accepted in a run are recorded; expected results are recomputed from them at the end.
module tb_gate16_checker;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, in_valid;
  logic [15:0] x, y, dut_out;

  logic        a_in_ready, a_busy, a_done, a_pass;
  logic [15:0] a_vec, a_err, a_fidx, a_fexp, a_fgot;
  logic        b_in_ready, b_busy, b_done, b_pass;
  logic [3:0]  b_vec, b_err, b_fidx;
  logic [15:0] b_fexp, b_fgot;

  int n_tests = 0;
  int n_fail  = 0;
  int mid_start = -1;

  logic [15:0] sx[$], sy[$], sg[$];
  logic [15:0] qx[$], qy[$], qg[$];

  always #5 clk = ~clk;

  gate16_checker #(.WIDTH(16), .CNT_W(16), .OP(0)) u_and (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
    .in_ready(a_in_ready), .x(x), .y(y), .dut_out(dut_out), .busy(a_busy),
    .done(a_done), .pass(a_pass), .vec_count(a_vec), .err_count(a_err),
    .first_err_idx(a_fidx), .first_err_exp(a_fexp), .first_err_got(a_fgot));

  gate16_checker #(.WIDTH(16), .CNT_W(4), .OP(2)) u_xor (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
    .in_ready(b_in_ready), .x(x), .y(y), .dut_out(dut_out), .busy(b_busy),
    .done(b_done), .pass(b_pass), .vec_count(b_vec), .err_count(b_err),
    .first_err_idx(b_fidx), .first_err_exp(b_fexp), .first_err_got(b_fgot));

  function automatic logic [15:0] gold(input int op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      1:       return a | b;
      2:       return a ^ b;
      3:       return ~(a & b);
      default: return a & b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input string tag, input int op, input int cw,
                           input logic rdy, input logic bsy, input logic dn, input logic ps,
                           input logic [31:0] vec, input logic [31:0] err, input logic [31:0] fidx,
                           input logic [31:0] fexp, input logic [31:0] fgot);
    int n, errs, first, maxv;
    logic [15:0] e_exp, e_got;
    n = qx.size(); errs = 0; first = -1; maxv = (1 << cw) - 1;
    e_exp = '0; e_got = '0;
    for (int i = 0; i < n; i++) begin
      if (gold(op, qx[i], qy[i]) != qg[i]) begin
        if (first < 0) begin
          first = i; e_exp = gold(op, qx[i], qy[i]); e_got = qg[i];
        end
        errs++;
      end
    end
    chk({tag, ".in_ready"}, rdy, 0);
    chk({tag, ".busy"}, bsy, 0);
    chk({tag, ".done"}, dn, 1);
    chk({tag, ".pass"}, ps, (errs == 0));
    chk({tag, ".vec_count"}, vec, (n > maxv) ? maxv : n);
    chk({tag, ".err_count"}, err, (errs > maxv) ? maxv : errs);
    if (first <= maxv) chk({tag, ".first_err_idx"}, fidx, (first < 0) ? 0 : first);
    chk({tag, ".first_err_exp"}, fexp, e_exp);
    chk({tag, ".first_err_got"}, fgot, e_got);
  endtask

  task automatic check_all(input string tag);
    check_dut({tag, ".and"}, 0, 16, a_in_ready, a_busy, a_done, a_pass, a_vec, a_err, a_fidx, a_fexp, a_fgot);
    check_dut({tag, ".xor"}, 2, 4, b_in_ready, b_busy, b_done, b_pass, b_vec, b_err, b_fidx, b_fexp, b_fgot);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".and_ctl"}, {a_in_ready, a_busy, a_done, a_pass}, 0);
    chk({tag, ".and_cnt"}, {a_vec, a_err}, 0);
    chk({tag, ".and_cap"}, {a_fidx, a_fexp}, 0);
    chk({tag, ".and_got"}, a_fgot, 0);
    chk({tag, ".xor_ctl"}, {b_in_ready, b_busy, b_done, b_pass}, 0);
    chk({tag, ".xor_cnt"}, {b_vec, b_err, b_fidx}, 0);
    chk({tag, ".xor_cap"}, {b_fexp, b_fgot}, 0);
  endtask

  task automatic pulse_start(input bit with_stop);
    @(negedge clk);
    start = 1'b1; stop = with_stop;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
  endtask

  // Runs the pending stimulus sx/sy/sg; stop is either its own pulse or shares the last vector
  task automatic run(input string tag, input bit stop_with_last, input bit gaps, input bit start_with_stop);
    int idx;
    qx.delete(); qy.delete(); qg.delete();
    pulse_start(start_with_stop);
    chk({tag, ".run_ready"}, {a_in_ready, b_in_ready, a_busy, b_busy}, 4'hF);
    chk({tag, ".run_clear"}, {a_done, a_pass, a_vec, b_vec}, 0);
    idx = 0;
    while (sx.size() > 0) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        in_valid = 1'b0;
        @(negedge clk);
        continue;
      end
      x = sx.pop_front(); y = sy.pop_front(); dut_out = sg.pop_front();
      in_valid = 1'b1;
      start = (idx == mid_start);
      stop  = stop_with_last && (sx.size() == 0);
      qx.push_back(x); qy.push_back(y); qg.push_back(dut_out);
      idx++;
      @(negedge clk);
      start = 1'b0;
    end
    if (!stop_with_last || qx.size() == 0) begin
      in_valid = 1'b0;
      stop = 1'b1;
      @(negedge clk);
    end
    // DRAIN cycle: offer junk that must not be accepted
    stop = 1'b0; in_valid = 1'b1; x = 16'($urandom); y = 16'($urandom); dut_out = 16'($urandom);
    chk({tag, ".drain_done"}, {a_done, b_done}, 0);
    chk({tag, ".drain_busy"}, {a_busy, b_busy, a_in_ready, b_in_ready}, 4'hC);
    @(negedge clk);
    in_valid = 1'b0;
    check_all(tag);
    mid_start = -1;
  endtask

  task automatic push_vec(input logic [15:0] a, input logic [15:0] b, input logic [15:0] g);
    sx.push_back(a); sy.push_back(b); sg.push_back(g);
  endtask

  initial begin
    int n, c;
    logic [15:0] a, b;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    x = '0; y = '0; dut_out = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    push_vec(16'h0000, 16'h0000, 16'h0000);
    push_vec(16'h0001, 16'h0001, 16'h0001);
    push_vec(16'h1263, 16'h2462, 16'h0062);
    push_vec(16'h0001, 16'h0000, 16'h0000);
    run("t1_pass", 1'b0, 1'b0, 1'b0);

    push_vec(16'h0000, 16'h0000, 16'h0000);
    push_vec(16'h0001, 16'h0001, 16'h0001);
    push_vec(16'h1263, 16'h2462, 16'h0063);
    push_vec(16'h0001, 16'h0000, 16'h0001);
    mid_start = 1;
    run("t2_errs", 1'b0, 1'b0, 1'b1);
    chk("t2_and_first_idx", a_fidx, 2);
    chk("t2_and_first_exp", a_fexp, 16'h0062);
    chk("t2_and_first_got", a_fgot, 16'h0063);

    push_vec(16'hFFFF, 16'h0F0F, 16'hF0F0);
    run("t3_stop_vec", 1'b1, 1'b0, 1'b0);
    chk("t3_xor_pass", {b_pass, b_vec}, {1'b1, 4'd1});

    qx.delete(); qy.delete(); qg.delete();
    pulse_start(1'b0);
    for (int i = 0; i < 3; i++) begin
      x = 16'($urandom); y = 16'($urandom); dut_out = 16'($urandom); in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero("t4_async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("t4_idle");
    for (int i = 0; i < 6; i++) push_vec(16'($urandom), 16'($urandom), 16'($urandom));
    run("t4_fresh", 1'b0, 1'b0, 1'b0);

    run("t5_empty", 1'b0, 1'b0, 1'b0);
    pulse_start(1'b0);
    chk("t5_restart_clear", {a_done, a_pass, b_done, b_pass}, 0);
    chk("t5_restart_run", {a_busy, a_in_ready, a_vec}, {2'b11, 16'd0});
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 7; r++) begin
      n = (r == 6) ? 20 : $urandom_range(1, 24);
      for (int i = 0; i < n; i++) begin
        a = 16'($urandom); b = 16'($urandom);
        c = (r == 0) ? 0 : $urandom_range(0, 3);
        push_vec(a, b, (c < 2) ? (a & b) : (c == 2) ? (a ^ b) : 16'($urandom));
      end
      run($sformatf("rand%0d", r), r[0], 1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
